// File: rtl/riscv_wb_pkg.sv
// Shared types for the register-file writeback path: the buffered result entry
// and the per-cycle arbitration outcome.
package riscv_wb_pkg;

    localparam int RegAddrW = 5;
    localparam int RegsNum  = 32;
    localparam int DataW    = 32;

    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic [DataW-1:0]    data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of long-latency writeback entries; pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wb_entry_t i_push_entry,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = IdxW + 1;

    wb_entry_t       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign o_head  = mem_q[rd_ptr_q[IdxW-1:0]];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= i_push_entry;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and buffered long-latency results onto the single register-file
// write port, tracks outstanding long-latency destinations, and stalls the ALU
// when a buffered result has waited too long.
module reg_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int DataWidth   = DataW,
    parameter int FifoDepth   = 2,
    parameter int StarveLimit = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_alu_valid,
    input  logic [RegAddrW-1:0]  i_alu_rd,
    input  logic [DataWidth-1:0] i_alu_data,
    output logic                 o_alu_stall,
    input  logic                 i_lsu_valid,
    output logic                 o_lsu_ready,
    input  logic [RegAddrW-1:0]  i_lsu_rd,
    input  logic [DataWidth-1:0] i_lsu_data,
    input  logic                 i_issue_valid,
    input  logic [RegAddrW-1:0]  i_issue_rd,
    output logic [RegsNum-1:0]   o_pending,
    output logic [RegAddrW-1:0]  o_wreg,
    output logic [DataWidth-1:0] o_wdata,
    output logic                 o_we
);

    localparam int CntW = $clog2(StarveLimit + 1);

    logic [CntW-1:0]      starve_q, starve_d;
    logic                 we_q, we_d;
    logic [RegAddrW-1:0]  wreg_q, wreg_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [RegsNum-1:0]   pending_q, pending_d;

    wb_src_e   src;
    wb_entry_t push_entry, fifo_head;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign o_alu_stall = (starve_q == CntW'(StarveLimit));
    assign o_lsu_ready = !fifo_full;

    // rd==0 results are handshaked but never stored, so they can never write x0.
    assign fifo_push  = i_lsu_valid && !fifo_full && (i_lsu_rd != '0);
    assign push_entry = '{rd: i_lsu_rd, data: DataW'(i_lsu_data)};
    assign fifo_pop   = (src == WB_LSU);

    wb_fifo #(
        .Depth(FifoDepth)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (fifo_push),
        .i_push_entry(push_entry),
        .i_pop       (fifo_pop),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_head      (fifo_head)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        src = WB_NONE;
        if (o_alu_stall) begin
            if (!fifo_empty) src = WB_LSU;
        end else if (i_alu_valid && (i_alu_rd != '0)) begin
            src = WB_ALU;
        end else if (!fifo_empty) begin
            src = WB_LSU;
        end
    end

    always_comb begin
        starve_d = (fifo_empty || fifo_pop) ? '0 : starve_q + CntW'(1);

        we_d    = (src != WB_NONE);
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        unique case (src)
            WB_ALU: begin
                wreg_d  = i_alu_rd;
                wdata_d = i_alu_data;
            end
            WB_LSU: begin
                wreg_d  = fifo_head.rd;
                wdata_d = DataWidth'(fifo_head.data);
            end
            default: ;
        endcase

        // Clear before set so a fresh issue to the same rd stays pending.
        pending_d = pending_q;
        if (fifo_pop) pending_d[fifo_head.rd] = 1'b0;
        if (i_issue_valid && (i_issue_rd != '0)) pending_d[i_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q  <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign o_we      = we_q;
    assign o_wreg    = wreg_q;
    assign o_wdata   = wdata_q;
    assign o_pending = pending_q;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Producer side of the register file write port: merges ALU writeback and long-latency (load/mul-div) writeback into the single write port.
- Drives the register file's `o_wreg`/`o_wdata`/`o_we`.
- Buffers long-latency results in a small FIFO and tracks outstanding long-latency destinations in a pending scoreboard for the hazard logic.
- Guarantees forward progress of buffered results via an ALU-stall starvation guard.

Parameters:
- DataWidth, 32, register data width.
- FifoDepth, 2, long-latency result buffer entries; power of two, >= 2.
- StarveLimit, 4, consecutive cycles a non-empty FIFO head may lose arbitration before ALU is stalled; >= 1.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_alu_valid  in  1  ALU result valid this cycle (no ready; accepted unless o_alu_stall).
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  DataWidth  ALU result.
- o_alu_stall  out  1  upstream must hold ALU result this cycle.
- i_lsu_valid  in  1  long-latency result valid.
- o_lsu_ready  out  1  FIFO can accept (= !full).
- i_lsu_rd  in  5  long-latency destination.
- i_lsu_data  in  DataWidth  long-latency result.
- i_issue_valid  in  1  long-latency op issued this cycle.
- i_issue_rd  in  5  its destination.
- o_pending  out  32  per-register "result outstanding" mask; bit 0 constant 0.
- o_wreg  out  5  register file write address.
- o_wdata  out  DataWidth  register file write data.
- o_we  out  1  register file write enable.

Behaviour:
- Reset: i_rst high at a rising edge clears o_we=0, o_wreg=0, o_wdata=0, o_pending=0, FIFO empty, starve counter=0. Reset mid-operation discards all FIFO contents and pending bits; no write issues on the cycle after reset.
- After reset: o_lsu_ready=1, o_alu_stall=0.
- Write outputs are registered: the winner in cycle N appears on o_we/o_wreg/o_wdata in cycle N+1. o_we=0 when there is no winner; o_wreg/o_wdata then hold their previous values.
- LSU enqueue: push on i_lsu_valid && o_lsu_ready.
  - Entries with i_lsu_rd==0 are accepted and silently dropped (not stored).
  - No bypass: an entry pushed in cycle N is poppable from N+1, so earliest write is N+2.
- Arbitration per cycle, in priority order:
  1. o_alu_stall=1: FIFO head pops and wins; i_alu_valid is ignored.
  2. i_alu_valid && i_alu_rd!=0: ALU wins.
  3. FIFO non-empty: head pops and wins.
  4. Otherwise no write.
- ALU with rd==0 never writes and lets the FIFO drain that cycle.
- FIFO:
  - Circular, pointers wrap modulo FifoDepth, with an extra wrap bit for full/empty.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Full blocks push via o_lsu_ready=0.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and does not pop.
  - Clears on any pop or when the FIFO is empty.
  - o_alu_stall = (counter == StarveLimit), combinational from the registered counter; that cycle forces a pop, and the counter clears.
  - Counter width is $clog2(StarveLimit+1).
- Scoreboard:
  - Set: i_issue_valid && i_issue_rd!=0 sets o_pending[i_issue_rd] at the next edge.
  - Clear: a FIFO pop winning for rd clears o_pending[rd] at the same edge that raises o_we. The register file's write-through makes the value visible that cycle.
  - Simultaneous set and clear of the same rd: set wins (new issue supersedes).
  - ALU writes never touch o_pending.

Decomposition:
- Package riscv_wb_pkg:
  - RegAddrW=5, RegsNum=32.
  - typedef struct packed wb_entry_t {rd, data}; data width is parameterised via the module, so the struct holds rd plus a localparam-sized data field.
  - typedef enum wb_src_e {WB_NONE, WB_ALU, WB_LSU} for the arbitration result.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t, parameter Depth, with ports push/pop/full/empty/head. The arbiter, scoreboard and starve counter stay in reg_wb_arbiter.

Test Plan:
- Reset: hold i_rst 2 cycles with all valids high -> o_we=0, o_pending=0, o_lsu_ready=1, o_alu_stall=0; first cycle after release, o_we=0.
- ALU path: cycle N alu_valid rd=5 data=0xDEADBEEF -> N+1 o_we=1, o_wreg=5, o_wdata=0xDEADBEEF; N+2 o_we=0.
- LSU + scoreboard: issue rd=7; later lsu_valid rd=7 data=0x00001234 at N with no ALU -> o_pending[7]=1 until N+2; at N+2 o_we=1, o_wreg=7, o_pending[7]=0.
- Priority/full: ALU valid rd=3 every cycle, push LSU rd=8 then rd=9 -> ALU writes each cycle, o_lsu_ready=0 after the second push (FifoDepth=2), third LSU held without loss.
- Starvation: ALU rd=4 continuously, one FIFO entry rd=10 -> after 4 losing cycles o_alu_stall=1 for one cycle, next cycle o_wreg=10; ALU resumes the cycle after.
- x0 and collisions:
  - alu rd=0 -> no write.
  - lsu rd=0 -> accepted, never written.
  - issue rd=0 -> o_pending[0]=0.
  - issue rd=7 same cycle as rd=7 pop -> o_pending[7] stays 1.
